// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch responder.
// The response word width is fixed by fetch_rsp_t at DEF_DATA_WIDTH.
package fetch_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DEPTH      = 256;
    localparam int DEF_LATENCY    = 2;
    localparam int DEF_Q_DEPTH    = 4;

    // Widest byte address the index helper accepts; narrower addresses are zero-extended.
    localparam int ADDR_MAX = 64;

    typedef struct packed {
        logic                      err;
        logic [DEF_DATA_WIDTH-1:0] data;
    } fetch_rsp_t;

    function automatic logic [ADDR_MAX-1:0] word_index(input logic [ADDR_MAX-1:0] addr);
        return addr >> 2;
    endfunction

endpackage

// File: rtl/fetch_rsp_fifo.sv
// Synchronous response FIFO; an extra pointer bit separates full from empty.
module fetch_rsp_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = DEF_Q_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  fetch_rsp_t               push_data,
    input  logic                     pop,
    output fetch_rsp_t               pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = (PW + 1)'(1);

    fetch_rsp_t  slots [DEPTH];
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage is left unreset; the top masks the head while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            slots[wr_ptr[PW-1:0]] <= push_data;
        end
    end

    assign empty    = (wr_ptr == rd_ptr);
    assign count    = wr_ptr - rd_ptr;
    assign pop_data = slots[rd_ptr[PW-1:0]];

endmodule

// File: rtl/fetch_responder.sv
// Instruction-memory responder: credit-gated requests, fixed-latency read pipeline, in-order response queue.
// Define FETCH_RSP_ERR_EN to enable misaligned / out-of-range fault reporting.
module fetch_responder
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int LATENCY    = DEF_LATENCY,
    parameter int Q_DEPTH    = DEF_Q_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_data,
    output logic                      rsp_err,
    input  logic                      ld_en,
    input  logic [$clog2(DEPTH)-1:0]  ld_addr,
    input  logic [DATA_WIDTH-1:0]     ld_data
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(Q_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(Q_DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [CNT_W-1:0]      outstanding;
    logic                  accept;
    logic                  pop;
    logic [ADDR_MAX-1:0]   full_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic                  fault;

    logic                  pipe_valid [LATENCY];
    logic                  pipe_err   [LATENCY];
    logic [DATA_WIDTH-1:0] pipe_data  [LATENCY];

    fetch_rsp_t            push_rsp;
    fetch_rsp_t            head_rsp;
    logic                  q_empty;
    logic [CNT_W-1:0]      q_count_unused;

    // Credits come from a registered count, so neither ready depends on the other side's valid/ready.
    assign req_ready = (outstanding < CNT_MAX);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = !q_empty;
    assign pop       = rsp_valid && rsp_ready;

    assign full_idx  = word_index(ADDR_MAX'(req_addr));
    assign rd_idx    = full_idx[IDX_W-1:0];

`ifdef FETCH_RSP_ERR_EN
    assign fault = (req_addr[1:0] != 2'b00) || (full_idx[ADDR_MAX-1:IDX_W] != '0);
`else
    logic unused_idx_bits;
    assign fault           = 1'b0;
    assign unused_idx_bits = ^full_idx[ADDR_MAX-1:IDX_W];
`endif

    // Memory is deliberately outside the reset domain so loads survive a reset.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // Stage 0 reads the array, so a same-edge load is seen only by later requests.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < LATENCY; k++) begin
                pipe_valid[k] <= 1'b0;
                pipe_err[k]   <= 1'b0;
                pipe_data[k]  <= '0;
            end
        end else begin
            pipe_valid[0] <= accept;
            pipe_err[0]   <= accept && fault;
            pipe_data[0]  <= (accept && !fault) ? mem[rd_idx] : '0;
            for (int k = 1; k < LATENCY; k++) begin
                pipe_valid[k] <= pipe_valid[k-1];
                pipe_err[k]   <= pipe_err[k-1];
                pipe_data[k]  <= pipe_data[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outstanding <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   outstanding <= outstanding + CNT_ONE;
                2'b01:   outstanding <= outstanding - CNT_ONE;
                default: outstanding <= outstanding;
            endcase
        end
    end

    assign push_rsp.err  = pipe_err[LATENCY-1];
    assign push_rsp.data = pipe_data[LATENCY-1];

    // The credit limit bounds queue occupancy, so the pipeline pushes unconditionally.
    fetch_rsp_fifo #(
        .DEPTH(Q_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (pipe_valid[LATENCY-1]),
        .push_data (push_rsp),
        .pop       (pop),
        .pop_data  (head_rsp),
        .empty     (q_empty),
        .count     (q_count_unused)
    );

    assign rsp_data = rsp_valid ? head_rsp.data : '0;
    assign rsp_err  = rsp_valid && head_rsp.err;

endmodule

// File: tb/tb_fetch_responder.sv
// Directed and scoreboarded bench for fetch_responder; honours FETCH_RSP_ERR_EN when defined.
module tb_fetch_responder;
    import fetch_pkg::*;

    localparam int DEPTH   = 256;
    localparam int NUM_RND = 1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        ld_en = 1'b0;
    logic [7:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;

    int errors = 0;
    int checks = 0;
    logic [31:0] mem_model [DEPTH];
    logic [31:0] words [4];

    fetch_responder dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int idx, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = 8'(idx);
        ld_data = d;
        step();
        ld_en = 1'b0;
        mem_model[idx] = d;
    endtask

    task automatic single_fetch(input logic [31:0] addr, output logic [31:0] data,
                                output logic err, output bit ok);
        int n;
        ok = 1'b0;
        data = '0;
        err = 1'b0;
        rsp_ready = 1'b1;
        req_addr = addr;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        step();
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        if (rsp_valid) begin
            data = rsp_data;
            err = rsp_err;
            ok = 1'b1;
            step();
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        step();
        step();
        checks += 4;
        if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready); end
        if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        if (rsp_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_rsp_data: got %h expected 0", rsp_data); end
        if (rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_err: got %b expected 0", rsp_err); end
        reset = 1'b1;
        step();
        step();
        checks += 2;
        if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_req_ready: got %b expected 1", req_ready); end
        if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_rsp_valid: got %b expected 0", rsp_valid); end
    endtask

    task automatic preload_memory();
        for (int i = 0; i < DEPTH; i++) begin
            load_word(i, (32'(i) * 32'h9E3779B1) ^ 32'h0BADF00D);
        end
    endtask

    task automatic test_in_order();
        words[0] = 32'h00000013;
        words[1] = 32'h00100093;
        words[2] = 32'h00200113;
        words[3] = 32'h00308193;
        for (int i = 0; i < 4; i++) load_word(i, words[i]);
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) begin
                checks++;
                if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_req_ready[%0d]: got %b expected 1", i, req_ready); end
                req_valid = 1'b1;
                req_addr = 32'(i * 4);
            end else begin
                req_valid = 1'b0;
            end
            step();
            checks++;
            if (rsp_valid !== (i >= 2 && i <= 5)) begin
                errors++;
                $display("[TB] FAIL b2b_rsp_valid[%0d]: got %b expected %b", i, rsp_valid, (i >= 2 && i <= 5));
            end
            if (i >= 2 && i <= 5) begin
                checks++;
                if (rsp_data !== words[i-2]) begin
                    errors++;
                    $display("[TB] FAIL b2b_rsp_data[%0d]: got %h expected %h", i, rsp_data, words[i-2]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int acc;
        acc = 0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1;
            req_addr = 32'(i * 4);
            if (req_ready) acc++;
            step();
        end
        req_valid = 1'b0;
        step();
        step();
        checks += 4;
        if (acc !== 4) begin errors++; $display("[TB] FAIL bp_accepted: got %0d expected 4", acc); end
        if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_req_ready_full: got %b expected 0", req_ready); end
        if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_rsp_valid: got %b expected 1", rsp_valid); end
        if (rsp_data !== words[0]) begin errors++; $display("[TB] FAIL bp_head: got %h expected %h", rsp_data, words[0]); end
        rsp_ready = 1'b1;
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_before_pop: got %b expected 0", req_ready); end
        step();
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_after_pop: got %b expected 1", req_ready); end
        for (int j = 1; j < 4; j++) begin
            checks += 2;
            if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_drain_valid[%0d]: got %b expected 1", j, rsp_valid); end
            if (rsp_data !== words[j]) begin errors++; $display("[TB] FAIL bp_drain_data[%0d]: got %h expected %h", j, rsp_data, words[j]); end
            step();
        end
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drained: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_faults();
        logic [31:0] d;
        logic        e;
        bit          ok;
        logic [31:0] exp_d;
        logic        exp_e;
`ifdef FETCH_RSP_ERR_EN
        exp_d = 32'h0;
        exp_e = 1'b1;
`else
        exp_d = mem_model[0];
        exp_e = 1'b0;
`endif
        single_fetch(32'h1002, d, e, ok);
        checks += 3;
        if (!ok) begin errors++; $display("[TB] FAIL misaligned_timeout: got none expected response"); end
        if (d !== exp_d) begin errors++; $display("[TB] FAIL misaligned_data: got %h expected %h", d, exp_d); end
        if (e !== exp_e) begin errors++; $display("[TB] FAIL misaligned_err: got %b expected %b", e, exp_e); end
        single_fetch(32'h400, d, e, ok);
        checks += 3;
        if (!ok) begin errors++; $display("[TB] FAIL range_timeout: got none expected response"); end
        if (d !== exp_d) begin errors++; $display("[TB] FAIL range_data: got %h expected %h", d, exp_d); end
        if (e !== exp_e) begin errors++; $display("[TB] FAIL range_err: got %b expected %b", e, exp_e); end
        single_fetch(32'h3FC, d, e, ok);
        checks += 3;
        if (!ok) begin errors++; $display("[TB] FAIL last_word_timeout: got none expected response"); end
        if (d !== mem_model[255]) begin errors++; $display("[TB] FAIL last_word_data: got %h expected %h", d, mem_model[255]); end
        if (e !== 1'b0) begin errors++; $display("[TB] FAIL last_word_err: got %b expected 0", e); end
    endtask

    task automatic test_load_collision();
        logic [31:0] old_word;
        logic [31:0] d;
        logic        e;
        bit          ok;
        int          n;
        old_word = mem_model[2];
        rsp_ready = 1'b1;
        ld_en = 1'b1;
        ld_addr = 8'd2;
        ld_data = 32'hDEADBEEF;
        req_valid = 1'b1;
        req_addr = 32'h8;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL collide_req_ready: got %b expected 1", req_ready); end
        step();
        ld_en = 1'b0;
        req_valid = 1'b0;
        mem_model[2] = 32'hDEADBEEF;
        n = 0;
        while (!rsp_valid && n < 10) begin
            step();
            n++;
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== old_word) begin
            errors++;
            $display("[TB] FAIL collide_old_word: got %b/%h expected 1/%h", rsp_valid, rsp_data, old_word);
        end
        step();
        single_fetch(32'h8, d, e, ok);
        checks++;
        if (!ok || d !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL collide_new_word: got %h expected deadbeef", d);
        end
    endtask

    task automatic test_random();
        logic [32:0] sb [$];
        logic [32:0] exp;
        int          sent;
        int          popped;
        int          cycles;
        int          idx;
        bit          prev_stall;
        logic [31:0] prev_data;
        logic        prev_err;
        sent = 0;
        popped = 0;
        cycles = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        prev_err = 1'b0;
        while ((sent < NUM_RND || sb.size() != 0) && cycles < 20000) begin
            if (prev_stall) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_data !== prev_data || rsp_err !== prev_err) begin
                    errors++;
                    $display("[TB] FAIL stall_hold: got %b/%h expected 1/%h", rsp_valid, rsp_data, prev_data);
                end
            end
            idx = $urandom_range(0, DEPTH - 1);
            req_valid = (sent < NUM_RND) && ($urandom_range(0, 3) != 0);
            req_addr = {22'b0, idx[7:0], 2'b00};
            rsp_ready = ($urandom_range(0, 3) != 0);
            ld_en = ($urandom_range(0, 7) == 0);
            ld_addr = 8'($urandom_range(0, DEPTH - 1));
            ld_data = $urandom;
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL rnd_unexpected: got %h expected no response", rsp_data);
                end else begin
                    exp = sb.pop_front();
                    if ({rsp_err, rsp_data} !== exp) begin
                        errors++;
                        $display("[TB] FAIL rnd_data[%0d]: got %b/%h expected %b/%h", popped, rsp_err, rsp_data, exp[32], exp[31:0]);
                    end
                end
                popped++;
            end
            if (req_valid && req_ready) begin
                sb.push_back({1'b0, mem_model[idx]});
                sent++;
            end
            if (ld_en) mem_model[ld_addr] = ld_data;
            prev_stall = rsp_valid && !rsp_ready;
            prev_data = rsp_data;
            prev_err = rsp_err;
            step();
            cycles++;
        end
        ld_en = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        checks += 2;
        if (popped !== NUM_RND || cycles >= 20000) begin
            errors++;
            $display("[TB] FAIL rnd_count: got %0d expected %0d", popped, NUM_RND);
        end
        if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rnd_leftover: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_reset_mid_burst();
        bit          any_valid;
        logic [31:0] d;
        logic        e;
        bit          ok;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_addr = 32'(i * 4);
            step();
        end
        req_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks += 4;
        if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_req_ready: got %b expected 1", req_ready); end
        if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_rsp_valid: got %b expected 0", rsp_valid); end
        if (rsp_data !== 32'h0) begin errors++; $display("[TB] FAIL mid_reset_rsp_data: got %h expected 0", rsp_data); end
        if (rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_rsp_err: got %b expected 0", rsp_err); end
        step();
        reset = 1'b1;
        any_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (rsp_valid) any_valid = 1'b1;
        end
        checks++;
        if (any_valid !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_stray: got %b expected 0", any_valid); end
        single_fetch(32'h0, d, e, ok);
        checks++;
        if (!ok || d !== mem_model[0]) begin
            errors++;
            $display("[TB] FAIL post_reset_mem: got %h expected %h", d, mem_model[0]);
        end
    endtask

    initial begin
        $display("[TB] fetch_responder bench start");
        test_reset();
        preload_memory();
        test_in_order();
        test_backpressure();
        test_faults();
        test_load_collision();
        test_random();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
